// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// UART_TX_ARBITER_TAG_EN adds the TAG state used for source tagging.
package uart_tx_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_ARB       = 3'd0,
`ifdef UART_TX_ARBITER_TAG_EN
    ST_TAG       = 3'd1,
`endif
    ST_LOAD      = 3'd2,
    ST_WAIT_LOW  = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } arb_state_t;

  localparam logic [7:0] NEWLINE_BYTE = 8'h0A;
  localparam logic [7:0] TAG_BASE     = 8'h30;
  localparam int         RETRY_COUNT  = 4;

  function automatic logic [7:0] tag_byte(input int unsigned id);
    return TAG_BASE + 8'(id);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Source-side and transmitter-side signals of the UART transmit arbiter.
// master: the arbiter; slave: the sources plus the UART transmitter.
interface uart_tx_arbiter_if #(
  parameter int NUM_SRC        = 4,
  parameter int DATA_BIT_COUNT = 8
);
  localparam int IDX_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]                src_valid;
  logic [NUM_SRC*DATA_BIT_COUNT-1:0] src_data;
  logic [NUM_SRC-1:0]                src_ready;
  logic [DATA_BIT_COUNT-1:0]         tx_data;
  logic                              tx_data_ready;
  logic                              tx_done;
  logic [IDX_W-1:0]                  grant_id;
  logic                              busy;

  modport master (
    input  src_valid, src_data, tx_done,
    output src_ready, tx_data, tx_data_ready, grant_id, busy
  );

  modport slave (
    output src_valid, src_data, tx_done,
    input  src_ready, tx_data, tx_data_ready, grant_id, busy
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: first request after ptr, restricted to the holder when locked.
module rr_pick #(
  parameter int NUM_SRC = 4,
  parameter int IDX_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               lock_en,
  input  logic [IDX_W-1:0]   holder,
  output logic               valid,
  output logic [IDX_W-1:0]   index
);

  logic [NUM_SRC-1:0] req_eff;

  always_comb begin
    int j;
    j       = 0;
    req_eff = lock_en ? (req & (NUM_SRC'(1) << holder)) : req;
    valid   = 1'b0;
    index   = '0;
    // Walk from farthest to nearest so the nearest request after ptr wins.
    for (int k = NUM_SRC; k >= 1; k--) begin
      j = int'(ptr) + k;
      if (j >= NUM_SRC) j = j - NUM_SRC;
      if (req_eff[j]) begin
        valid = 1'b1;
        index = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates byte sources onto one UART transmitter with line lock until newline.
// UART_TX_ARBITER_TAG_EN: prefix a 0x30+id tag byte whenever the source changes.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_SRC        = 4,
  parameter int DATA_BIT_COUNT = 8,
  parameter int LOCK_TIMEOUT   = 1024
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.master bus
);
  // state        | meaning
  // ST_ARB       | pick a source, accept its byte
  // ST_TAG       | (tag build) swap held byte for the source tag
  // ST_LOAD      | one-cycle start strobe to the transmitter
  // ST_WAIT_LOW  | wait for tx_done to drop, retry strobe after RETRY_COUNT
  // ST_WAIT_HIGH | wait for the frame to finish

  localparam int IDX_W   = $clog2(NUM_SRC);
  localparam int IDLE_W  = $clog2(LOCK_TIMEOUT + 1);
  localparam int RETRY_W = $clog2(RETRY_COUNT);

  arb_state_t                state;
  logic [IDX_W-1:0]          rr_ptr;
  logic                      lock_on;
  logic [IDX_W-1:0]          holder;
  logic [IDLE_W-1:0]         idle_cnt;
  logic [RETRY_W-1:0]        retry_cnt;
  logic [NUM_SRC-1:0]        src_ready;
  logic [DATA_BIT_COUNT-1:0] tx_data;
  logic                      tx_data_ready;
  logic [IDX_W-1:0]          grant_id;
  logic                      busy;
  logic                      pick_valid;
  logic [IDX_W-1:0]          pick_idx;
  logic [DATA_BIT_COUNT-1:0] pick_byte;
`ifdef UART_TX_ARBITER_TAG_EN
  logic [IDX_W-1:0]          last_src;
  logic                      last_valid;
  logic                      tag_pending;
  logic [DATA_BIT_COUNT-1:0] data_hold;
`endif

  rr_pick #(.NUM_SRC(NUM_SRC), .IDX_W(IDX_W)) u_rr_pick (
    .req     (bus.src_valid),
    .ptr     (rr_ptr),
    .lock_en (lock_on),
    .holder  (holder),
    .valid   (pick_valid),
    .index   (pick_idx)
  );

  assign pick_byte         = bus.src_data[int'(pick_idx)*DATA_BIT_COUNT +: DATA_BIT_COUNT];
  assign bus.src_ready     = src_ready;
  assign bus.tx_data       = tx_data;
  assign bus.tx_data_ready = tx_data_ready;
  assign bus.grant_id      = grant_id;
  assign bus.busy          = busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_ARB;
      rr_ptr        <= IDX_W'(NUM_SRC - 1);
      lock_on       <= 1'b0;
      holder        <= '0;
      idle_cnt      <= '0;
      retry_cnt     <= '0;
      src_ready     <= '0;
      tx_data       <= '0;
      tx_data_ready <= 1'b0;
      grant_id      <= '0;
      busy          <= 1'b0;
`ifdef UART_TX_ARBITER_TAG_EN
      last_src      <= '0;
      last_valid    <= 1'b0;
      tag_pending   <= 1'b0;
      data_hold     <= '0;
`endif
    end else begin
      src_ready     <= '0;
      tx_data_ready <= 1'b0;
      case (state)
        ST_ARB: begin
          if (pick_valid) begin
            tx_data   <= pick_byte;
            src_ready <= NUM_SRC'(1) << pick_idx;
            grant_id  <= pick_idx;
            rr_ptr    <= pick_idx;
            holder    <= pick_idx;
            lock_on   <= (pick_byte != DATA_BIT_COUNT'(NEWLINE_BYTE));
            idle_cnt  <= '0;
            busy      <= 1'b1;
`ifdef UART_TX_ARBITER_TAG_EN
            last_src   <= pick_idx;
            last_valid <= 1'b1;
            if (!last_valid || (pick_idx != last_src)) begin
              state <= ST_TAG;
            end else begin
              state         <= ST_LOAD;
              tx_data_ready <= 1'b1;
            end
`else
            state         <= ST_LOAD;
            tx_data_ready <= 1'b1;
`endif
          end else if (lock_on && !bus.src_valid[holder]) begin
            if (idle_cnt == IDLE_W'(LOCK_TIMEOUT - 1)) begin
              lock_on  <= 1'b0;
              idle_cnt <= '0;
            end else begin
              idle_cnt <= idle_cnt + IDLE_W'(1);
            end
          end
        end
`ifdef UART_TX_ARBITER_TAG_EN
        ST_TAG: begin
          data_hold     <= tx_data;
          tx_data       <= DATA_BIT_COUNT'(tag_byte(32'(grant_id)));
          tag_pending   <= 1'b1;
          state         <= ST_LOAD;
          tx_data_ready <= 1'b1;
        end
`endif
        ST_LOAD: begin
          state     <= ST_WAIT_LOW;
          retry_cnt <= RETRY_W'(RETRY_COUNT - 1);
        end
        ST_WAIT_LOW: begin
          if (!bus.tx_done) begin
            state <= ST_WAIT_HIGH;
          end else if (retry_cnt == '0) begin
            state         <= ST_LOAD;
            tx_data_ready <= 1'b1;
          end else begin
            retry_cnt <= retry_cnt - RETRY_W'(1);
          end
        end
        ST_WAIT_HIGH: begin
          if (bus.tx_done) begin
`ifdef UART_TX_ARBITER_TAG_EN
            if (tag_pending) begin
              tag_pending   <= 1'b0;
              tx_data       <= data_hold;
              state         <= ST_LOAD;
              tx_data_ready <= 1'b1;
            end else begin
              state <= ST_ARB;
              busy  <= 1'b0;
            end
`else
            state <= ST_ARB;
            busy  <= 1'b0;
`endif
          end
        end
        default: begin
          state <= ST_ARB;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
